// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- general-purpose register file, two read ports, one write port.
//
// 2**ADDR_WIDTH registers of DATA_WIDTH bits. Register 0 is hard-wired to
// zero. Reads are combinational; writes land on the rising edge of clk.
// A synchronous active-low reset clears every register and beats any write
// requested on the same edge.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN  - write-through forwarding: a read of the register
//                        being written this cycle returns write_data before
//                        the edge. Never active during reset, never for r0.
//                        Without the macro, reads return the stored value.
//
// Ports:
//   clk         in   1           sole clock, rising edge
//   rst_n       in   1           synchronous reset, active low
//   read_reg1   in   ADDR_WIDTH  port-1 read address (rs)
//   read_reg2   in   ADDR_WIDTH  port-2 read address (rt)
//   write_reg   in   ADDR_WIDTH  write address (post destination mux)
//   write_data  in   DATA_WIDTH  writeback value
//   reg_write   in   1           write enable
//   read_data1  out  DATA_WIDTH  port-1 data (ALU operand A)
//   read_data2  out  DATA_WIDTH  port-2 data (ALU operand B / store data)
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // A write to address 0 is not a write at all; qualifying it once here
  // keeps both the storage decode and the bypass path from touching r0.
  logic write_req;
  assign write_req = reg_write && (write_reg != '0);

  // Flat read view of the register array. Entry 0 is a constant zero
  // rather than storage, so r0 cannot read non-zero under any condition.
  logic [DATA_WIDTH-1:0] reg_view [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_view[gi] = '0;
      end else begin : g_store
        logic [DATA_WIDTH-1:0] value_reg;
        logic                  write_sel;

        // One-hot decode: only the addressed register sees its enable,
        // so at most one register changes per edge.
        assign write_sel = write_req && (write_reg == ADDR_WIDTH'(gi));

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            value_reg <= '0;
          end else if (write_sel) begin
            value_reg <= write_data;
          end
        end

        assign reg_view[gi] = value_reg;
      end
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  // Forwarding only when the write will actually commit on the coming
  // edge: not during reset, and never for r0 (write_req excludes it).
  logic fwd1;
  logic fwd2;
  assign fwd1 = rst_n && write_req && (read_reg1 == write_reg);
  assign fwd2 = rst_n && write_req && (read_reg2 == write_reg);

  assign read_data1 = fwd1 ? write_data : reg_view[read_reg1];
  assign read_data2 = fwd2 ? write_data : reg_view[read_reg2];
`else
  assign read_data1 = reg_view[read_reg1];
  assign read_data2 = reg_view[read_reg2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- self-checking bench for reg_file.
// A behavioural model (plain array of register values plus the forwarding
// rule) predicts both read ports; a compare process checks them on every
// falling edge once the first reset edge has happened. Directed scenarios
// add hand-computed literal checks. Build with +define+REGFILE_BYPASS_EN to
// exercise the forwarding build; the bench follows the same macro.
// ---------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] model_mem [32];
  bit          reset_seen = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_mem[i] <= 32'h0;
      reset_seen <= 1'b1;
    end else if (reg_write && write_reg != 5'd0) begin
      model_mem[write_reg] <= write_data;
    end
  end

  function automatic logic [31:0] predict(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (BYPASS && rst_n && reg_write && write_reg != 5'd0 && addr == write_reg)
      return write_data;
    return model_mem[addr];
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (reset_seen) begin
      logic [31:0] e1;
      logic [31:0] e2;
      e1 = predict(read_reg1);
      e2 = predict(read_reg2);
      n_cmp++;
      if (read_data1 !== e1) begin
        n_fail++;
        $display("FAIL model_port1 t=%0t addr=%0d got=%h expected=%h", $time, read_reg1, read_data1, e1);
      end
      n_cmp++;
      if (read_data2 !== e2) begin
        n_fail++;
        $display("FAIL model_port2 t=%0t addr=%0d got=%h expected=%h", $time, read_reg2, read_data2, e2);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    tick();
    reg_write  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hCAFE_F00D;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    tick();
    reg_write = 1'b0;
    tick();
    rst_n = 1'b1;

    // all 32 addresses read zero on both ports after reset
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      if (i == 0 || i == 3 || i == 31) begin
        check($sformatf("reset_zero_p1_r%0d", i), read_data1, 32'h0);
        check($sformatf("reset_zero_p2_r%0d", 31 - i), read_data2, 32'h0);
      end
      tick();
    end

    // basic writes, two ports reading different registers
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd31, 32'h1234_5678);
    read_reg1 = 5'd5; read_reg2 = 5'd31; #1;
    check("r5_port1", read_data1, 32'hDEAD_BEEF);
    check("r31_port2", read_data2, 32'h1234_5678);
    read_reg1 = 5'd31; read_reg2 = 5'd31; #1;
    check("same_addr_p1", read_data1, 32'h1234_5678);
    check("same_addr_p2", read_data2, 32'h1234_5678);

    // write to r0 discarded, r0 reads zero even during the write cycle
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF; #1;
    check("r0_during_write_p1", read_data1, 32'h0);
    check("r0_during_write_p2", read_data2, 32'h0);
    tick();
    reg_write = 1'b0; #1;
    check("r0_after_write_p1", read_data1, 32'h0);
    check("r0_after_write_p2", read_data2, 32'h0);

    // forwarding vs stored value in the write cycle
    wr(5'd7, 32'h0000_0011);
    read_reg1 = 5'd7; read_reg2 = 5'd5;
    reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h0000_0022; #1;
    check("r7_pre_edge", read_data1, BYPASS ? 32'h0000_0022 : 32'h0000_0011);
    check("r5_unaffected", read_data2, 32'hDEAD_BEEF);
    tick();
    reg_write = 1'b0; #1;
    check("r7_post_edge", read_data1, 32'h0000_0022);

    // reset beats a simultaneous write; no forwarding during reset
    wr(5'd3, 32'h0000_AAAA);
    read_reg1 = 5'd3; read_reg2 = 5'd5;
    rst_n = 1'b0; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h0000_5555; #1;
    check("r3_in_reset_no_fwd", read_data1, 32'h0000_AAAA);
    tick();
    reg_write = 1'b0; #1;
    check("r3_after_reset", read_data1, 32'h0);
    check("r5_after_reset", read_data2, 32'h0);

    // reset released: the very next edge writes
    rst_n = 1'b1;
    wr(5'd3, 32'h0000_0077);
    check("r3_resume", read_data1, 32'h0000_0077);

    // random writes, random reads -- checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      read_reg1  = 5'($urandom_range(0, 31));
      read_reg2  = 5'($urandom_range(0, 31));
      reg_write  = 1'b1;
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      tick();
    end
    reg_write = 1'b0;

    // pin known contents before the hold test
    wr(5'd9, 32'h0BAD_F00D);
    wr(5'd30, 32'h8000_0001);

    // 100 cycles with reg_write low and random address/data on the write bus
    for (int i = 0; i < 100; i++) begin
      reg_write  = 1'b0;
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = 5'($urandom_range(0, 31));
      read_reg2  = 5'($urandom_range(0, 31));
      tick();
    end
    read_reg1 = 5'd9; read_reg2 = 5'd30; #1;
    check("hold_r9", read_data1, 32'h0BAD_F00D);
    check("hold_r30", read_data2, 32'h8000_0001);

    // sweep every address through both ports against the model
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'((i + 7) % 32);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register and data-port width.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width; depth = 2**ADDR_WIDTH (32).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 read_reg1  input  ADDR_WIDTH  port-1 read address (rs).
REQ-006 read_reg2  input  ADDR_WIDTH  port-2 read address (rt).
REQ-007 write_reg  input  ADDR_WIDTH  write address (rd/rt, post dest-mux).
REQ-008 write_data  input  DATA_WIDTH  writeback value (ALU result or load data).
REQ-009 reg_write  input  1  write enable.
REQ-010 read_data1  output  DATA_WIDTH  port-1 data; drives ALU operand A.
REQ-011 read_data2  output  DATA_WIDTH  port-2 data; drives ALU operand B path and store data.

Function
REQ-012 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits.
REQ-013 Reads SHALL be combinational, zero-cycle latency from address to data.
REQ-014 Write SHALL occur on rising clk when rst_n=1, reg_write=1 and write_reg!=0; new value visible on reads after that edge.
REQ-015 reg_write=0 SHALL leave all registers unchanged.
REQ-016 Register 0 SHALL read as all-zero at all times; writes to address 0 SHALL be discarded.
REQ-017 Reads of address 0 SHALL return 0 even when write_reg=0 and reg_write=1 in the same cycle, bypass or not.
REQ-018 Both ports SHALL independently read any address, including both ports reading the same address.
REQ-019 At most one register SHALL change per clock edge.
REQ-020 Write data SHALL be stored unmodified; no sign extension, no truncation.

Reset
REQ-021 On a rising clk with rst_n=0, all registers SHALL be cleared to 0.
REQ-022 A write requested on the same edge as reset SHALL be discarded; reset wins.
REQ-023 After the first reset edge, read_data1 and read_data2 SHALL be 0 for every address until a write occurs.
REQ-024 Before the first reset edge, register contents are undefined (X permitted in simulation).
REQ-025 rst_n deasserted mid-program SHALL resume normal writes on the next edge with no extra latency.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL select write-through forwarding.
REQ-027 With REGFILE_BYPASS_EN defined: when rst_n=1, reg_write=1, write_reg!=0 and read_regN==write_reg, read_dataN SHALL equal write_data in the same cycle, before the edge.
REQ-028 With REGFILE_BYPASS_EN undefined: read_dataN SHALL return the stored pre-edge value in that case.
REQ-029 Bypass SHALL be inactive while rst_n=0.
REQ-030 Port list, reset behaviour and register-0 rules SHALL be identical in both builds.

Verification
REQ-031 Reset then read all 32 addresses on both ports -> every read_data = 0x00000000.
REQ-032 Write 0xDEADBEEF to r5, write 0x12345678 to r31, then read_reg1=5, read_reg2=31 -> read_data1=0xDEADBEEF, read_data2=0x12345678.
REQ-033 reg_write=1, write_reg=0, write_data=0xFFFFFFFF, then read r0 on both ports -> 0x00000000.
REQ-034 r7=0x00000011; same cycle reg_write=1, write_reg=7, write_data=0x00000022, read_reg1=7 -> pre-edge read_data1=0x00000022 with REGFILE_BYPASS_EN, 0x00000011 without; 0x00000022 after the edge in both builds.
REQ-035 r3=0x0000AAAA; drive rst_n=0 together with a write of 0x5555 to r3 for one edge -> r3 reads 0x00000000 after the edge.
REQ-036 Hold reg_write=0 for 100 cycles with random write_reg and write_data -> all previously written values unchanged.
